// File: rtl/mrc_pkg.sv
// Shared types and default geometry for the memory result checker.
package mrc_pkg;

  localparam int unsigned MRC_DATA_W    = 21;
  localparam int unsigned MRC_ADDR_W    = 12;
  localparam int unsigned MRC_NUM_WORDS = 1024;
  localparam int unsigned MRC_RD_LAT    = 1;
  localparam int unsigned MRC_CNT_W     = 11;
  // Drain counter width; covers read latencies up to 4 with margin.
  localparam int unsigned MRC_LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } mrc_state_e;

endpackage

// File: rtl/mrc_lat_pipe.sv
// Fixed-depth shift register that tracks read-side metadata across memory latency.
module mrc_lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  // Shift metadata one stage per clock; cleared on reset so no stale compares retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_result_checker.sv
// Sweeps result and golden memories in lockstep and reports mismatch statistics.
module mem_result_checker
  import mrc_pkg::*;
#(
  parameter int unsigned DATA_W    = MRC_DATA_W,
  parameter int unsigned ADDR_W    = MRC_ADDR_W,
  parameter int unsigned NUM_WORDS = MRC_NUM_WORDS,
  parameter int unsigned RD_LAT    = MRC_RD_LAT,
  parameter int unsigned CNT_W     = MRC_CNT_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic [DATA_W-1:0] gold_data,
  output logic              busy,
  output logic              check_done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned LCW = MRC_LAT_CNT_W;

  mrc_state_e        state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              fev_q, fev_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [LCW-1:0]    lat_cnt_q, lat_cnt_d;

  logic [ADDR_W:0]   pipe_out;
  logic              cmp_valid_c;
  logic [ADDR_W-1:0] cmp_addr_c;
  logic              mismatch_c;

  // Carry {valid, addr} of each issued read until its data returns.
  mrc_lat_pipe #(
    .DEPTH (RD_LAT),
    .W     (ADDR_W + 1)
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (nrst),
    .d_i   ({rd_en_q, rd_addr_q}),
    .q_o   (pipe_out)
  );

  assign cmp_valid_c = pipe_out[ADDR_W];
  assign cmp_addr_c  = pipe_out[ADDR_W-1:0];
  assign mismatch_c  = cmp_valid_c && (res_data != gold_data);

  // Next-state, compare accounting and registered output decode.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    fev_d     = fev_q;
    fea_d     = fea_q;
    lat_cnt_d = lat_cnt_q;

    if (mismatch_c) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
      if (!fev_q) begin
        fev_d = 1'b1;
        fea_d = cmp_addr_c;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          err_cnt_d = '0;
          fev_d     = 1'b0;
          fea_d     = '0;
          pass_d    = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (rd_addr_q == ADDR_W'(NUM_WORDS - 1)) begin
          state_d   = ST_DRAIN;
          rd_en_d   = 1'b0;
          lat_cnt_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // The final compare retires in the last drain cycle, so pass sees err_cnt_d.
        if (lat_cnt_q == LCW'(RD_LAT - 1)) begin
          state_d = ST_REPORT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          lat_cnt_d = lat_cnt_q + LCW'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      fev_q     <= 1'b0;
      fea_q     <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      fev_q     <= fev_d;
      fea_q     <= fea_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign busy            = busy_q;
  assign check_done      = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Self-checking bench for mem_result_checker: default build plus an RD_LAT=3, NUM_WORDS=1 build.
module tb_mem_result_checker;

  localparam int unsigned DW   = 21;
  localparam int unsigned AW   = 12;
  localparam int unsigned NW   = 1024;
  localparam int unsigned LAT  = 1;
  localparam int unsigned CW   = 11;
  localparam int unsigned LAT2 = 3;
  localparam int unsigned NW2  = 1;
  localparam int unsigned DONE_CYC  = NW + LAT + 1;
  localparam int unsigned DONE_CYC2 = NW2 + LAT2 + 1;

  typedef struct {
    int unsigned err;
    logic        fev;
    logic [AW-1:0] fea;
    logic        pass;
    int unsigned done;
  } exp_t;

  typedef struct {
    int unsigned pat;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst, start, start2;
  logic          rd_en, busy, check_done, pass, fev;
  logic [AW-1:0] rd_addr, fea;
  logic [CW-1:0] err_cnt;
  logic [DW-1:0] res_rd, gold_rd;

  logic          rd_en2, busy2, check_done2, pass2, fev2;
  logic [AW-1:0] rd_addr2, fea2;
  logic [CW-1:0] err_cnt2;
  logic [DW-1:0] res2_word, gold2_word;
  logic [DW-1:0] r2 [LAT2];
  logic [DW-1:0] g2 [LAT2];

  logic [DW-1:0] mem_c  [1 << AW];
  logic [DW-1:0] gold_m [1 << AW];

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  vec_t vecs[4];

  mem_result_checker #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .RD_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .res_data(res_rd), .gold_data(gold_rd), .busy(busy), .check_done(check_done),
    .pass(pass), .err_cnt(err_cnt), .first_err_valid(fev), .first_err_addr(fea)
  );

  mem_result_checker #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW2), .RD_LAT(LAT2), .CNT_W(CW)
  ) dut2 (
    .clk(clk), .nrst(nrst), .start(start2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .res_data(r2[LAT2-1]), .gold_data(g2[LAT2-1]), .busy(busy2), .check_done(check_done2),
    .pass(pass2), .err_cnt(err_cnt2), .first_err_valid(fev2), .first_err_addr(fea2)
  );

  // Counter width must hold NUM_WORDS.
  initial begin
    if (CW < $clog2(NW + 1)) $fatal(1, "FAIL cnt_w_legal: CNT_W=%0d too narrow", CW);
  end

  // Latency-1 memories; unread cycles present differing data so un-gated compares would show.
  always @(posedge clk) begin
    if (rd_en) begin
      res_rd  <= mem_c[rd_addr];
      gold_rd <= gold_m[rd_addr];
    end else begin
      res_rd  <= '1;
      gold_rd <= '0;
    end
  end

  // Latency-3 single-word memories for the second build.
  always @(posedge clk) begin
    r2[0] <= rd_en2 ? res2_word  : DW'(5);
    g2[0] <= rd_en2 ? gold2_word : '0;
    for (int i = 1; i < LAT2; i++) begin
      r2[i] <= r2[i-1];
      g2[i] <= g2[i-1];
    end
  end

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int unsigned pat);
    for (int i = 0; i < NW; i++) begin
      gold_m[i] = DW'(i);
      mem_c[i]  = DW'(i);
      if (pat == 2) begin
        gold_m[i] = '0;
        mem_c[i]  = DW'(21'h1FFFFF);
      end
    end
    if (pat == 1) begin
      mem_c[5][20]    = ~mem_c[5][20];
      mem_c[300][20]  = ~mem_c[300][20];
      mem_c[1023][20] = ~mem_c[1023][20];
    end
    if (pat == 3) mem_c[1023][0] = ~mem_c[1023][0];
  endtask

  task automatic run_sweep(input int unsigned pat, input exp_t e, input int extra_at,
                           input bit start_on_done);
    int   n;
    int   done_n;
    int   seq_bad;
    exp_t got;
    fill(pat);
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    n      = 0;
    done_n = 0;
    seq_bad = 0;
    while (done_n == 0 && n < 1200) begin
      @(negedge clk);
      n++;
      start = (extra_at != 0) && (n == extra_at);
      if (n == 1) begin
        check("clear_err_cnt", 64'(err_cnt), 64'(0));
        check("clear_first_valid", 64'(fev), 64'(0));
        check("clear_pass", 64'(pass), 64'(0));
      end
      if (rd_en !== (n <= NW)) seq_bad++;
      if (n <= NW && rd_addr !== AW'(n - 1)) seq_bad++;
      if (busy !== (n < DONE_CYC)) seq_bad++;
      if (check_done === 1'b1) done_n = n;
    end
    check("issue_busy_sequence", 64'(seq_bad), 64'(0));
    check("check_done_cycle", 64'(done_n), 64'(e.done));
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 64'(1), 64'(0));
    end else begin
      got = sb_q.pop_front();
      check("err_cnt", 64'(err_cnt), 64'(got.err));
      check("first_err_valid", 64'(fev), 64'(got.fev));
      check("first_err_addr", 64'(fea), 64'(got.fea));
      check("pass", 64'(pass), 64'(got.pass));
    end
    if (start_on_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_at_done_busy", 64'(busy), 64'(0));
      check("start_at_done_rd_en", 64'(rd_en), 64'(0));
    end
    @(negedge clk);
    @(negedge clk);
    check("hold_err_cnt", 64'(err_cnt), 64'(e.err));
    check("hold_pass", 64'(pass), 64'(e.pass));
    check("done_single_pulse", 64'(check_done), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_check_done"}, 64'(check_done), 64'(0));
    check({tag, "_pass"}, 64'(pass), 64'(0));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
    check({tag, "_first_valid"}, 64'(fev), 64'(0));
    check({tag, "_first_addr"}, 64'(fea), 64'(0));
  endtask

  initial begin
    exp_t e2;
    exp_t got2;
    int   n;
    int   done_n;
    int   stray;

    vecs[0] = '{pat: 0, e: '{err: 0,    fev: 1'b0, fea: AW'(0),    pass: 1'b1, done: DONE_CYC}};
    vecs[1] = '{pat: 1, e: '{err: 3,    fev: 1'b1, fea: AW'(5),    pass: 1'b0, done: DONE_CYC}};
    vecs[2] = '{pat: 2, e: '{err: 1024, fev: 1'b1, fea: AW'(0),    pass: 1'b0, done: DONE_CYC}};
    vecs[3] = '{pat: 3, e: '{err: 1,    fev: 1'b1, fea: AW'(1023), pass: 1'b0, done: DONE_CYC}};

    nrst = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    res2_word = '0;
    gold2_word = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Table-driven sweeps.
    for (int v = 0; v < 4; v++) begin
      run_sweep(vecs[v].pat, vecs[v].e, 0, 1'b0);
    end

    // Start while busy is ignored; start in the check_done cycle is ignored too.
    run_sweep(1, vecs[1].e, 400, 1'b1);
    // A start in IDLE clears the previous status and reruns.
    run_sweep(0, vecs[0].e, 0, 1'b0);

    // Reset mid-sweep with errors already counted.
    fill(2);
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midsweep_err_cnt", 64'(err_cnt), 64'(498));
    nrst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    stray = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (check_done === 1'b1 || busy === 1'b1) stray++;
    end
    check("no_done_after_reset", 64'(stray), 64'(0));
    run_sweep(0, vecs[0].e, 0, 1'b0);

    // RD_LAT=3, NUM_WORDS=1 build: single error at address 0.
    res2_word  = DW'(1);
    gold2_word = '0;
    e2 = '{err: 1, fev: 1'b1, fea: AW'(0), pass: 1'b0, done: DONE_CYC2};
    sb_q.push_back(e2);
    @(negedge clk);
    start2 = 1'b1;
    n = 0;
    done_n = 0;
    while (done_n == 0 && n < 40) begin
      @(negedge clk);
      n++;
      start2 = 1'b0;
      if (n == 1) begin
        check("lat3_rd_en_c1", 64'(rd_en2), 64'(1));
        check("lat3_rd_addr_c1", 64'(rd_addr2), 64'(0));
      end
      if (n == 2) check("lat3_rd_en_c2", 64'(rd_en2), 64'(0));
      if (n == 4) check("lat3_err_before_compare", 64'(err_cnt2), 64'(0));
      if (check_done2 === 1'b1) done_n = n;
    end
    check("lat3_done_cycle", 64'(done_n), 64'(DONE_CYC2));
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 64'(1), 64'(0));
    end else begin
      got2 = sb_q.pop_front();
      check("lat3_err_cnt", 64'(err_cnt2), 64'(got2.err));
      check("lat3_first_valid", 64'(fev2), 64'(got2.fev));
      check("lat3_first_addr", 64'(fea2), 64'(got2.fea));
      check("lat3_pass", 64'(pass2), 64'(got2.pass));
    end
    check("lat3_busy_at_done", 64'(busy2), 64'(0));
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_result_checker.md
Name: mem_result_checker

Overview:
- Hardware checker downstream of the matrix engine's top controller; launched by the controller's done pulse.
- Sweeps the result memory (MEM_C) and a golden-reference memory in lockstep and compares each word.
- Reports mismatch count, first failing address and pass/fail, so self-checking runs need no bench-side array walk.

Parameters:
- DATA_W, 21, width of result and golden words.
- ADDR_W, 12, memory address width (4096-entry arrays).
- NUM_WORDS, 1024, number of words compared, starting at address 0; must be 1..2^ADDR_W.
- RD_LAT, 1, read latency of both memories in cycles; must be 1..4.
- CNT_W, 11, error counter width; must be at least clog2(NUM_WORDS+1).

Ports:
- clk  in  1  rising-edge clock shared with top controller.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle launch pulse, normally the controller's done.
- rd_en  out  1  read strobe to both memories.
- rd_addr  out  ADDR_W  common read address.
- res_data  in  DATA_W  result memory read data, valid RD_LAT cycles after rd_en.
- gold_data  in  DATA_W  golden memory read data, same timing as res_data.
- busy  out  1  high from the cycle after start acceptance until check_done.
- check_done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  high when err_cnt == 0; valid from check_done onward.
- err_cnt  out  CNT_W  number of mismatching words.
- first_err_valid  out  1  high once a mismatch has been recorded.
- first_err_addr  out  ADDR_W  address of the lowest mismatching word.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rd_en=0, rd_addr=0, busy=0, check_done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_addr=0, FSM in IDLE, valid pipe cleared.
- FSM states: IDLE, ISSUE, DRAIN, REPORT.
- IDLE: start=1 moves to ISSUE; clears err_cnt, first_err_valid, first_err_addr and pass.
- ISSUE: rd_en=1 every cycle; rd_addr runs 0..NUM_WORDS-1, incrementing by 1 per cycle. After issuing NUM_WORDS-1, go to DRAIN.
- DRAIN: rd_en=0; stay RD_LAT cycles until the last compare has retired, then go to REPORT.
- REPORT: check_done=1 for one cycle; pass=(err_cnt==0), accounting for a compare retiring that same cycle. Then return to IDLE.
- Compare pipeline:
  - A valid flag and address are delayed RD_LAT stages alongside each read.
  - When the delayed valid is high and res_data != gold_data (all DATA_W bits, unsigned compare), err_cnt increments by 1.
  - If first_err_valid is 0 at that point, first_err_addr takes the delayed address and first_err_valid is set.
- Timing with start at cycle 0:
  - Reads are issued in cycles 1..NUM_WORDS.
  - Compares occur in cycles 1+RD_LAT..NUM_WORDS+RD_LAT.
  - check_done occurs in cycle NUM_WORDS+RD_LAT+1. For defaults this is cycle 1026.
- Status outputs: err_cnt, pass and first_err_* hold their values in IDLE until the next accepted start.
- Counter width: err_cnt cannot overflow with a legal CNT_W. No saturation logic is required; the bench asserts CNT_W legality at elaboration.
- start while busy or in REPORT: ignored; no restart and no status change.
- start in the same cycle as check_done: ignored. The next start must arrive in IDLE.
- Reset mid-sweep: everything returns to reset values immediately. Partial results are discarded and no check_done pulse is produced.
- NUM_WORDS=1: ISSUE lasts exactly one cycle.

Decomposition:
- Shared package mrc_pkg holds the FSM state enum (IDLE/ISSUE/DRAIN/REPORT), default widths (DATA_W=21, ADDR_W=12) and NUM_WORDS=1024, matching the existing memory geometry.
- One sub-module, mrc_lat_pipe: RD_LAT-deep shift register carrying {valid, addr}, asynchronously reset to 0.
- Compare, count and FSM logic stay in the top of the block.

Test Plan:
- All-match: MEM_C and golden both hold i at address i; start pulse -> check_done at cycle 1026, err_cnt=0, pass=1, first_err_valid=0, busy high for cycles 1..1025.
- Sparse errors: corrupt words at addresses 5, 300 and 1023 (bit 20 flipped) -> err_cnt=3, first_err_addr=5, first_err_valid=1, pass=0.
- All-mismatch: golden=0x00000, results=0x1FFFFF -> err_cnt=1024, first_err_addr=0, no counter wrap.
- Start while busy: second start at cycle 400 -> ignored; check_done still at cycle 1026 with correct counts. A subsequent start in IDLE clears status and reruns.
- Reset mid-sweep: nrst low at cycle 500 with errors already counted -> all outputs 0 immediately, no check_done. A fresh start completes normally.
- RD_LAT=3, NUM_WORDS=1 build: one error at address 0 -> compare at cycle 4, check_done at cycle 5, err_cnt=1, first_err_addr=0.
